csr_bank: RTL and testbench

// - Parametrised successor to the 3-register H2F control bank: the Avalon-MM slave through which the Linux driver configures capture.
// - Holds the CONTROL, PKT_BEGIN and PKT_END registers plus a scratch register.
// - Adds byte enables, a 1-cycle read response with readdatavalid, a self-clearing START pulse, a saturating captured-packet counter,
//   and a maskable W1C interrupt block.
// - Sits between the HPS lightweight H2F bridge and the capture/DMA datapath.

---
 rtl/csr_bank_pkg.sv | 20 ++
 rtl/csr_irq_ctrl.sv | 28 ++
 rtl/csr_bank.sv | 113 +++++++++++
 tb/tb_csr_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/csr_bank_pkg.sv
// Shared register map and helpers for the capture-control CSR bank.
// Holds the word offsets, the START bit position and the offset type.
package csr_bank_pkg;
    localparam int CSR_OFF_W = 3;
    typedef logic [CSR_OFF_W-1:0] csr_addr_t;

    localparam csr_addr_t CSR_CONTROL   = 3'd0;
    localparam csr_addr_t CSR_PKT_BEGIN = 3'd1;
    localparam csr_addr_t CSR_PKT_END   = 3'd2;
    localparam csr_addr_t CSR_STATUS    = 3'd3;
    localparam csr_addr_t CSR_IRQ_PEND  = 3'd4;
    localparam csr_addr_t CSR_IRQ_EN    = 3'd5;
    localparam csr_addr_t CSR_PKT_CNT   = 3'd6;
    localparam csr_addr_t CSR_SCRATCH   = 3'd7;

    // START sits directly above the mirrored state field.
    function automatic int start_bit(input int state_w);
        return state_w;
    endfunction
endpackage

// File: rtl/csr_irq_ctrl.sv
// Interrupt pending/enable block: sticky pending bits with W1C clear,
// byte-masked enable register and a registered level irq.
module csr_irq_ctrl #(
    parameter int IRQ_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] evt,
    input  logic [IRQ_W-1:0] w1c,
    input  logic [IRQ_W-1:0] en_mask,
    input  logic [IRQ_W-1:0] en_wdata,
    output logic [IRQ_W-1:0] pend,
    output logic [IRQ_W-1:0] enable,
    output logic             irq
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend   <= '0;
            enable <= '0;
            irq    <= 1'b0;
        end else begin
            // A set in the same cycle as a clear wins.
            pend   <= (pend & ~w1c) | evt;
            enable <= (enable & ~en_mask) | (en_wdata & en_mask);
            irq    <= |(pend & enable);
        end
    end
endmodule

// File: rtl/csr_bank.sv
// Avalon-MM control/status bank for the capture datapath: CONTROL, packet
// window, status, interrupts, packet counter and scratch, 1-cycle reads.
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 3,
    parameter int STATE_W = 2,
    parameter int IRQ_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    input  logic [STATE_W-1:0]  state,
    input  logic [IRQ_W-1:0]    evt,
    input  logic                pkt_done,
    output logic [DATA_W-1:0]   out_control,
    output logic [DATA_W-1:0]   out_pkt_begin,
    output logic [DATA_W-1:0]   out_pkt_end,
    output logic                start_pulse,
    output logic                irq
);
    localparam int NB    = DATA_W / 8;
    localparam int START = start_bit(STATE_W);
    // Only bits above START are stored in CONTROL.
    localparam logic [DATA_W-1:0] CTRL_RW = {DATA_W{1'b1}} << (STATE_W + 1);

    logic [DATA_W-1:0]  bmask;
    logic [DATA_W-1:0]  ctrl_q, pkt_cnt, scratch_q, rd_val;
    logic [STATE_W-1:0] state_q;
    logic [IRQ_W-1:0]   pend, enable;
    csr_addr_t          off;
    logic               in_map, wr;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++) bmask[b*8 +: 8] = {8{byteenable[b]}};
    end

    assign off    = address[CSR_OFF_W-1:0];
    assign in_map = (address >> CSR_OFF_W) == '0;
    assign wr     = write & in_map;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                 input logic [DATA_W-1:0] wd,
                                                 input logic [DATA_W-1:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    csr_irq_ctrl #(.IRQ_W(IRQ_W)) u_irq (
        .clk      (clk),
        .reset    (reset),
        .evt      (evt),
        .w1c      ((wr && off == CSR_IRQ_PEND) ? (writedata[IRQ_W-1:0] & bmask[IRQ_W-1:0]) : '0),
        .en_mask  ((wr && off == CSR_IRQ_EN) ? bmask[IRQ_W-1:0] : '0),
        .en_wdata (writedata[IRQ_W-1:0]),
        .pend     (pend),
        .enable   (enable),
        .irq      (irq)
    );

    assign out_control = ctrl_q | {{(DATA_W-STATE_W){1'b0}}, state_q};

    always_comb begin
        rd_val = '0;
        if (in_map) begin
            case (off)
                CSR_CONTROL:   rd_val = out_control;
                CSR_PKT_BEGIN: rd_val = out_pkt_begin;
                CSR_PKT_END:   rd_val = out_pkt_end;
                CSR_STATUS:    rd_val[STATE_W:0] = {pend != '0, state_q};
                CSR_IRQ_PEND:  rd_val[IRQ_W-1:0] = pend;
                CSR_IRQ_EN:    rd_val[IRQ_W-1:0] = enable;
                CSR_PKT_CNT:   rd_val = pkt_cnt;
                default:       rd_val = scratch_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q        <= '0;
            state_q       <= '0;
            out_pkt_begin <= '0;
            out_pkt_end   <= '0;
            pkt_cnt       <= '0;
            scratch_q     <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            start_pulse   <= 1'b0;
        end else begin
            state_q       <= state;
            readdatavalid <= read;
            if (read) readdata <= rd_val;
            start_pulse <= wr && off == CSR_CONTROL && byteenable[START/8] && writedata[START];
            if (wr && off == CSR_CONTROL)   ctrl_q        <= merge(ctrl_q, writedata, bmask) & CTRL_RW;
            if (wr && off == CSR_PKT_BEGIN) out_pkt_begin <= merge(out_pkt_begin, writedata, bmask);
            if (wr && off == CSR_PKT_END)   out_pkt_end   <= merge(out_pkt_end, writedata, bmask);
            if (wr && off == CSR_SCRATCH)   scratch_q     <= merge(scratch_q, writedata, bmask);
            // Clear-on-write ignores byteenable; a coincident packet counts as the first.
            if (wr && off == CSR_PKT_CNT)
                pkt_cnt <= pkt_done ? DATA_W'(1) : '0;
            else if (pkt_done && pkt_cnt != '1)
                pkt_cnt <= pkt_cnt + DATA_W'(1);
        end
    end
endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank with a register-level reference model
// checked against every output each cycle, plus literal expectations.
module tb_csr_bank;
    logic        clk = 1'b0, reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0, write = 1'b0, pkt_done = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [1:0]  state = '0;
    logic [3:0]  evt = '0;
    logic [31:0] readdata, out_control, out_pkt_begin, out_pkt_end;
    logic        readdatavalid, start_pulse, irq;
    logic        sat_load = 1'b0, running = 1'b0;
    int          total = 0, bad = 0;

    csr_bank #(.DATA_W(32), .ADDR_W(3), .STATE_W(2), .IRQ_W(4)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
        .readdatavalid(readdatavalid), .state(state), .evt(evt), .pkt_done(pkt_done),
        .out_control(out_control), .out_pkt_begin(out_pkt_begin), .out_pkt_end(out_pkt_end),
        .start_pulse(start_pulse), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values, updated per bus rules.
    logic [31:0] m_ctl, m_pb, m_pe, m_cnt, m_scr, m_rd;
    logic [3:0]  m_pend, m_en;
    logic [1:0]  m_state;
    logic        m_rdv, m_start, m_irq;

    function automatic logic [31:0] be2m(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] upd(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        return (old & ~be2m(be)) | (wd & be2m(be));
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_ctl | {30'b0, m_state};
            3'd1: return m_pb;
            3'd2: return m_pe;
            3'd3: return {29'b0, m_pend != 4'b0, m_state};
            3'd4: return {28'b0, m_pend};
            3'd5: return {28'b0, m_en};
            3'd6: return m_cnt;
            default: return m_scr;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctl <= '0; m_pb <= '0; m_pe <= '0; m_cnt <= '0; m_scr <= '0; m_rd <= '0;
            m_pend <= '0; m_en <= '0; m_state <= '0; m_rdv <= 1'b0; m_start <= 1'b0; m_irq <= 1'b0;
        end else begin
            m_state <= state;
            m_rdv   <= read;
            if (read) m_rd <= model_read(address);
            m_irq   <= (m_pend & m_en) != 4'b0;
            m_start <= write && address == 3'd0 && byteenable[0] && writedata[2];
            if (write && address == 3'd0) m_ctl <= upd(m_ctl, writedata, byteenable) & 32'hFFFF_FFF8;
            if (write && address == 3'd1) m_pb  <= upd(m_pb, writedata, byteenable);
            if (write && address == 3'd2) m_pe  <= upd(m_pe, writedata, byteenable);
            if (write && address == 3'd5) m_en  <= upd({28'b0, m_en}, writedata, byteenable) & 4'hF;
            if (write && address == 3'd7) m_scr <= upd(m_scr, writedata, byteenable);
            if (write && address == 3'd4)
                m_pend <= (m_pend & ~(writedata[3:0] & {4{byteenable[0]}})) | evt;
            else
                m_pend <= m_pend | evt;
            if (sat_load)                      m_cnt <= 32'hFFFF_FFFF;
            else if (write && address == 3'd6) m_cnt <= {31'b0, pkt_done};
            else if (pkt_done && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (running) begin
        chk("model readdata", readdata, m_rd);
        chk("model readdatavalid", {31'b0, readdatavalid}, {31'b0, m_rdv});
        chk("model out_control", out_control, m_ctl | {30'b0, m_state});
        chk("model out_pkt_begin", out_pkt_begin, m_pb);
        chk("model out_pkt_end", out_pkt_end, m_pe);
        chk("model start_pulse", {31'b0, start_pulse}, {31'b0, m_start});
        chk("model irq", {31'b0, irq}, {31'b0, m_irq});
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        step();
        write = 1'b0; byteenable = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
        chk(name, readdata, exp);
        chk({name, " valid"}, {31'b0, readdatavalid}, 32'd1);
    endtask

    initial begin
        running = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset readdatavalid", {31'b0, readdatavalid}, 32'd0);
        chk("reset out_control", out_control, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, "reset read");
        state = 2'b10;
        step();
        rd(3'd0, 32'h2, "control state");

        wr(3'd1, 32'hDEADBEEF, 4'b0101);
        chk("out_pkt_begin byteen", out_pkt_begin, 32'h00AD00EF);
        rd(3'd1, 32'h00AD00EF, "pkt_begin byteen");
        wr(3'd2, 32'h12345678, 4'b1111);
        rd(3'd2, 32'h12345678, "pkt_end");

        wr(3'd0, 32'h4, 4'b0001);
        chk("start_pulse high", {31'b0, start_pulse}, 32'd1);
        step();
        chk("start_pulse low", {31'b0, start_pulse}, 32'd0);
        rd(3'd0, 32'h2, "control start reads 0");
        wr(3'd0, 32'hA5A5_A5FF, 4'b0011);
        rd(3'd0, 32'h0000_A5FA, "control rw bits");

        evt = 4'b0011; step(); evt = '0;
        wr(3'd5, 32'h1, 4'b0001);
        step();
        chk("irq asserted", {31'b0, irq}, 32'd1);
        rd(3'd3, 32'h6, "status pending");
        evt = 4'b0001; wr(3'd4, 32'h1, 4'b0001); evt = '0;
        rd(3'd4, 32'h3, "set wins over w1c");
        wr(3'd4, 32'h3, 4'b0001);
        chk("irq one cycle late", {31'b0, irq}, 32'd1);
        step();
        chk("irq fallen", {31'b0, irq}, 32'd0);
        rd(3'd4, 32'h0, "pend cleared");

        pkt_done = 1'b1; repeat (5) step(); pkt_done = 1'b0;
        rd(3'd6, 32'd5, "pkt_cnt 5");
        pkt_done = 1'b1; wr(3'd6, 32'h0, 4'b0000); pkt_done = 1'b0;
        rd(3'd6, 32'd1, "pkt_cnt clear+done");
        force dut.pkt_cnt = 32'hFFFF_FFFF; sat_load = 1'b1;
        step();
        release dut.pkt_cnt; sat_load = 1'b0;
        pkt_done = 1'b1; step(); pkt_done = 1'b0;
        rd(3'd6, 32'hFFFF_FFFF, "pkt_cnt saturates");

        wr(3'd7, 32'h1111_1111, 4'b1111);
        address = 3'd7; writedata = 32'h2222_2222; byteenable = 4'hF; read = 1'b1; write = 1'b1;
        step();
        read = 1'b0; write = 1'b0;
        chk("rw same cycle old value", readdata, 32'h1111_1111);
        rd(3'd7, 32'h2222_2222, "scratch new value");

        address = 3'd7; read = 1'b1;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        chk("reset drops response", {31'b0, readdatavalid}, 32'd0);
        chk("reset readdata", readdata, 32'd0);
        chk("reset out_pkt_begin", out_pkt_begin, 32'd0);
        chk("reset out_control", out_control, 32'd0);
        chk("reset irq/start", {30'b0, irq, start_pulse}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("no late valid", {31'b0, readdatavalid}, 32'd0);
        rd(3'd0, 32'h2, "control after reset");
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
